// File: rtl/fpu_mant_mul_seq.sv
// Sequential shift-add mantissa multiplier: restores the hidden bit and
// forms the full-width product of {1,mant_a} x {1,mant_b}, one partial product per cycle.
module fpu_mant_mul_seq #(
    parameter int unsigned MANT_W = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [MANT_W-1:0]     mant_a,
    input  logic [MANT_W-1:0]     mant_b,
    output logic                  busy,
    output logic                  done,
    output logic [2*MANT_W+1:0]   product,
    output logic                  norm_shift
);

    localparam int unsigned OP_W   = MANT_W + 1;
    localparam int unsigned PROD_W = 2 * MANT_W + 2;
    localparam int unsigned CNT_W  = $clog2(MANT_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [OP_W-1:0]     opa_q, opa_d;
    logic [OP_W-1:0]     opb_q, opb_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic                norm_shift_q, norm_shift_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                pp_en;
    logic [PROD_W-1:0]   pp;
    logic [PROD_W-1:0]   sum;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            opa_q        <= '0;
            opb_q        <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            product_q    <= '0;
            norm_shift_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            product_q    <= product_d;
            norm_shift_q <= norm_shift_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    // Next-state, shift-add step and registered output flags
    always_comb begin
        state_d      = state_q;
        opa_d        = opa_q;
        opb_d        = opb_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        product_d    = product_q;
        norm_shift_d = norm_shift_q;

        pp_en = |(opb_q & (OP_W'(1) << cnt_q));
        pp    = pp_en ? (PROD_W'(opa_q) << cnt_q) : '0;
        sum   = acc_q + pp;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    opa_d   = {1'b1, mant_a};
                    opb_d   = {1'b1, mant_b};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                acc_d = sum;
                cnt_d = cnt_q + CNT_W'(1);
                // Final iteration publishes the sum including this cycle's partial product
                if (cnt_q == CNT_W'(MANT_W)) begin
                    product_d    = sum;
                    norm_shift_d = sum[PROD_W-1];
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign product    = product_q;
    assign norm_shift = norm_shift_q;

endmodule

// File: tb/tb_fpu_mant_mul_seq.sv
// Scoreboard bench for fpu_mant_mul_seq: expected products are queued at start
// and checked by a monitor on each done pulse; scenario tasks check timing.
module tb_fpu_mant_mul_seq;

    localparam int unsigned MANT_W = 10;
    localparam int unsigned PROD_W = 2 * MANT_W + 2;
    localparam int unsigned LAT    = MANT_W + 1;

    typedef struct packed {
        logic [PROD_W-1:0] prod;
        logic              ns;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [MANT_W-1:0] mant_a;
    logic [MANT_W-1:0] mant_b;
    logic              busy;
    logic              done;
    logic [PROD_W-1:0] product;
    logic              norm_shift;

    int   vectors;
    int   miscompares;
    exp_t exp_q[$];

    fpu_mant_mul_seq #(.MANT_W(MANT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mant_a     (mant_a),
        .mant_b     (mant_b),
        .busy       (busy),
        .done       (done),
        .product    (product),
        .norm_shift (norm_shift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b);
        longint unsigned p;
        exp_t e;
        p = longint'({1'b1, a}) * longint'({1'b1, b});
        e.prod = PROD_W'(p);
        e.ns   = e.prod[PROD_W-1];
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && done) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL sb_unexpected_done: got done=1 product=%h, required no done", product);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (product !== e.prod || norm_shift !== e.ns) begin
                    miscompares++;
                    $display("FAIL sb_product: got %h/ns=%b, required %h/ns=%b",
                             product, norm_shift, e.prod, e.ns);
                end
            end
        end
    end

    // Drive a one-cycle start at a negedge; returns at the negedge after the sampling edge
    task automatic launch(input logic [MANT_W-1:0] a, input logic [MANT_W-1:0] b);
        start  = 1'b1;
        mant_a = a;
        mant_b = b;
        exp_q.push_back(model(a, b));
        @(negedge clk);
        start  = 1'b0;
        mant_a = $urandom_range(0, (1 << MANT_W) - 1);
        mant_b = $urandom_range(0, (1 << MANT_W) - 1);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL launch_busy: got busy=%b, required 1", busy);
        end
    endtask

    // Wait (bounded) for done, check its latency, single-cycle width and busy release
    task automatic wait_done(input string name);
        int n;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
        vectors++;
        if (n != int'(LAT)) begin
            miscompares++;
            $display("FAIL %s_latency: got done at cycle %0d (0=timeout), required %0d", name, n, LAT);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_pulse: got done=%b busy=%b, required 0/0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || norm_shift !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got busy=%b done=%b product=%h ns=%b, required 0",
                     busy, done, product, norm_shift);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || norm_shift !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_hold: cycle %0d got busy=%b done=%b product=%h, required 0",
                         i, busy, done, product);
            end
        end
    endtask

    task automatic test_one_by_one();
        launch(10'h000, 10'h000);
        wait_done("one_by_one");
        vectors++;
        if (product !== 22'h100000 || norm_shift !== 1'b0) begin
            miscompares++;
            $display("FAIL one_by_one_hold: got %h/%b, required 100000/0", product, norm_shift);
        end
    endtask

    task automatic test_max();
        launch(10'h3FF, 10'h3FF);
        wait_done("max_ops");
        vectors++;
        if (product !== 22'h3FF001 || norm_shift !== 1'b1) begin
            miscompares++;
            $display("FAIL max_ops_hold: got %h/%b, required 3FF001/1", product, norm_shift);
        end
    endtask

    task automatic test_back_to_back();
        int d1;
        int d2;
        d1 = 0;
        d2 = 0;
        start  = 1'b1;
        mant_a = 10'h200;
        mant_b = 10'h200;
        exp_q.push_back(model(10'h200, 10'h200));
        exp_q.push_back(model(10'h200, 10'h000));
        @(negedge clk);
        mant_b = 10'h000;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (n == 13) start = 1'b0;
            if (done === 1'b1) begin
                if (d1 == 0) d1 = n;
                else if (d2 == 0) d2 = n;
            end
            if (n == 12) begin
                vectors++;
                if (busy !== 1'b0) begin
                    miscompares++;
                    $display("FAIL b2b_idle_gap: got busy=%b, required 0", busy);
                end
            end
            if (n >= 11 && n < 24) begin
                vectors++;
                if (product !== 22'h240000 || norm_shift !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_hold: cycle %0d got %h/%b, required 240000/1",
                             n, product, norm_shift);
                end
            end
        end
        vectors++;
        if (d1 != 11 || d2 != 24) begin
            miscompares++;
            $display("FAIL b2b_done_times: got %0d,%0d, required 11,24", d1, d2);
        end
        vectors++;
        if (product !== 22'h180000 || norm_shift !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second: got %h/%b, required 180000/0", product, norm_shift);
        end
    endtask

    task automatic test_start_while_busy();
        int dones;
        int first;
        dones = 0;
        first = 0;
        launch(10'h100, 10'h080);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                if (first == 0) first = n;
            end
            if (n == 2 || n == 11) begin
                start  = 1'b1;
                mant_a = 10'h3FF;
                mant_b = 10'h3FF;
            end else begin
                start = 1'b0;
            end
        end
        vectors++;
        if (dones != 1 || first != 11) begin
            miscompares++;
            $display("FAIL busy_ignore: got %0d done pulses first at %0d, required 1 at 11",
                     dones, first);
        end
        vectors++;
        if (product !== model(10'h100, 10'h080).prod || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_result: got %h busy=%b, required %h busy=0",
                     product, busy, model(10'h100, 10'h080).prod);
        end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        dones = 0;
        launch(10'h155, 10'h2AA);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || product !== '0 || norm_shift !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_reset: got busy=%b done=%b product=%h ns=%b, required 0",
                     busy, done, product, norm_shift);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        vectors++;
        if (dones != 0) begin
            miscompares++;
            $display("FAIL midrun_no_done: got %0d active cycles, required 0", dones);
        end
        launch(10'h155, 10'h2AA);
        wait_done("post_reset");
        vectors++;
        if (product !== model(10'h155, 10'h2AA).prod) begin
            miscompares++;
            $display("FAIL post_reset_product: got %h, required %h",
                     product, model(10'h155, 10'h2AA).prod);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            launch(MANT_W'($urandom), MANT_W'($urandom));
            wait_done("random");
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        mant_a      = '0;
        mant_b      = '0;
        test_reset();
        test_one_by_one();
        test_max();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid_run();
        test_random();
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sb_drain: got %0d pending results, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fpu_mant_mul_seq.md
# fpu_mant_mul_seq

Sequential mantissa-multiply controller for the FPU datapath. It accepts two fraction fields on a start strobe, restores the implicit leading one, and forms the full-width unsigned product with an iterative shift-add loop, one partial product per cycle. It signals completion with a one-cycle done pulse and holds the product for the normalisation/rounding stage. It replaces a combinational multiplier so the mantissa multiply fits the tile area budget.

## Interface
- MANT_W, 10, fraction width without the implicit bit (10 = binary16).
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- mant_a  in  MANT_W  fraction of operand A; sampled with start.
- mant_b  in  MANT_W  fraction of operand B; sampled with start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse: product valid.
- product  out  2*MANT_W+2  unsigned product of {1,mant_a} and {1,mant_b}.
- norm_shift  out  1  product[2*MANT_W+1]; high means product ≥ 2.0 and needs a one-bit right shift.

## Operation
- States: IDLE, RUN, DONE. Use a 2-bit encoding.
- IDLE with start=1:
  - Latch opa={1,mant_a} and opb={1,mant_b}.
  - Clear the accumulator (2*MANT_W+2 bits) and set the iteration counter cnt=0.
  - Go to RUN.
- IDLE with start=0: stay in IDLE.
- RUN, each cycle:
  - If opb[cnt]=1, set acc ← acc + (opa << cnt). Zero-extend opa to the accumulator width.
  - Then cnt ← cnt+1.
  - The accumulator cannot overflow because the final sum is at most (2^(MANT_W+1)−1)^2.
- RUN on the last iteration (cnt == MANT_W):
  - Write the final sum (including this iteration's add) into the product register.
  - Update norm_shift from the product MSB.
  - Go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- start while busy=1 (RUN or DONE) is ignored, not queued. mant_a and mant_b are not sampled then.
- product and norm_shift change only on the RUN→DONE transition. They hold their value through IDLE and through the next operation until that operation's DONE.
- Operands may change freely after the start-sampling edge.
- The counter is wide enough for MANT_W: $clog2(MANT_W+1) bits.

## Timing
- Reset (rst_n=0, at any time including mid-RUN):
  - state=IDLE.
  - busy=0, done=0, product=0, norm_shift=0.
  - Accumulator, counter and operand registers cleared.
  - Any in-flight operation is discarded and produces no done pulse.
  - The first start is accepted on the first rising edge with rst_n=1.
- Let start be sampled at edge E.
  - busy=1 from E through E+MANT_W+2, falling at that edge.
  - RUN iterations occur on edges E+1 … E+MANT_W+1.
  - done=1 and product valid after edge E+MANT_W+1. For MANT_W=10, that is after edge E+11.
  - IDLE is re-entered at edge E+MANT_W+2.
  - The earliest next accepted start is at edge E+MANT_W+3.
- Latency: MANT_W+1 cycles from start sampling to done. Throughput: one operation per MANT_W+3 cycles.
- A start held high continuously starts a new operation on every IDLE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use MANT_W=10.
- Reset then idle: rst_n=0 → busy=0, done=0, product=0, norm_shift=0. Release reset with start=0 for 20 cycles → outputs unchanged.
- 1.0×1.0: mant_a=0x000, mant_b=0x000, start pulse → done exactly 11 cycles after the sampling edge, for one cycle. product=0x100000, norm_shift=0.
- Max operands: mant_a=mant_b=0x3FF → product=0x3FF001, norm_shift=1.
- 1.5×1.5, then 1.5×1.0:
  - First: product=0x240000, norm_shift=1.
  - Hold start high with mant_b=0x000 → second operation accepted at edge E+13. Its done gives product=0x180000, norm_shift=0.
  - product holds 0x240000 until the second done.
- Start while busy: pulse start with new operands at E+3 and again during the DONE cycle → both ignored. Only one done pulse occurs, with the original result.
- Reset mid-RUN: assert rst_n=0 at E+5 for 2 cycles → all outputs 0 immediately (asynchronous) and no done pulse follows. A fresh start after release gives the correct result in 11 cycles.
